regfile_bank: RTL and testbench
===============================

Name: regfile_bank

Overview:
- Parametrised, clocked successor to the combinational register array in the datapath.
- Provides two asynchronous read ports and one synchronous write port. Register 0 is hardwired to zero.
- Adds a multi-cycle clear sweep with a busy handshake, a saturating accepted-write counter, and registered active-low debug LEDs.
- Sits between decode (read addresses) and writeback (write port) of the single-cycle/multi-cycle CPU.

Parameters:
- DATA_W, 32, register width in bits (matches `SIZE).
- ADDR_W, 5, address width.
- DEPTH, 32, number of registers; must be <= 2**ADDR_W.
- CNT_W, 16, width of the write counter.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  synchronous, active-high reset.
- rd_addr1  input  ADDR_W  read port 1 address.
- rd_addr2  input  ADDR_W  read port 2 address.
- rd_data1  output  DATA_W  read port 1 data (combinational).
- rd_data2  output  DATA_W  read port 2 data (combinational).
- wr_en  input  1  write request.
- wr_addr  input  ADDR_W  write address.
- wr_data  input  DATA_W  write data.
- clear_req  input  1  start clear sweep (sampled in IDLE only).
- busy  output  1  high while sweep is in progress.
- clear_done  output  1  one-cycle pulse when sweep completes.
- wr_cnt  output  CNT_W  count of accepted writes, saturating.
- led  output  4  active-low copy of wr_data[3:0] from the last accepted write.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Reset (sampled at posedge clk with reset=1):
  - All DEPTH registers <= 0.
  - FSM <= IDLE, sweep index <= 0.
  - busy=0, clear_done=0, wr_cnt=0, led=4'b1111 (all off).
  - Reset asserted mid-sweep aborts the sweep; no clear_done pulse.
- FSM states:
  - IDLE: busy=0.
    - clear_req=1 -> CLEAR, index <= 0.
    - clear_req=1 together with wr_en=1 in the same cycle: clear wins and the write is dropped (not counted, LED unchanged).
  - CLEAR: busy=1; each cycle register[index] <= 0 and index increments.
    - When index==DEPTH-1 is cleared -> DONE.
    - Sweep occupies exactly DEPTH cycles.
  - DONE: single cycle; clear_done=1, busy=0; -> IDLE unconditionally.
    - Writes in DONE are accepted.
    - clear_req in DONE is ignored.
- Write acceptance: accepted when wr_en=1, state != CLEAR, reset=0, and not preempted by clear_req in IDLE.
  - Accepted write: register[wr_addr] <= wr_data at posedge clk.
    - wr_addr==0 is not stored, but still counts and updates led.
    - wr_addr >= DEPTH: not stored, counts, updates led.
  - Writes presented while busy=1 are dropped silently. The producer must hold off on busy.
- Reads: rd_dataN = 0 if rd_addrN==0, rd_addrN>=DEPTH, or busy=1; otherwise register[rd_addrN]. Combinational, zero latency.
  - Same-cycle read of the address being written returns the OLD value (unless REGFILE_BYPASS_EN is defined).
- wr_cnt: +1 per accepted write; holds at 2**CNT_W-1 (no wrap).
- led: on accepted write, led <= ~wr_data[3:0] (registered, 1-cycle latency); otherwise holds.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: write-to-read forwarding. If wr_en=1, write would be accepted, wr_addr==rd_addrN, wr_addr!=0, and wr_addr<DEPTH, then rd_dataN = wr_data in the same cycle.
- Not defined: no forwarding; the read returns the stored value, and the new value is visible from the next cycle.
- The zero-register and busy rules apply in both builds.

Test Plan:
- Reset then read all addresses -> rd_data1/2 = 0, led=4'b1111, wr_cnt=0, busy=0.
- Write 0xDEADBEEF to addr 5, then read addr 5 on both ports next cycle -> 0xDEADBEEF; led=4'b0000 (~4'hF); wr_cnt=1.
- Write 0x12345678 to addr 0, read addr 0 -> 0; wr_cnt increments; led=4'b0111 (~4'h8).
- Same-cycle write 0xA5A5A5A5 and read addr 7 (old value 0x1) -> 0x1 without REGFILE_BYPASS_EN, 0xA5A5A5A5 with it; next cycle both builds read 0xA5A5A5A5.
- Fill regs 1..31, pulse clear_req -> busy high for exactly 32 cycles; a write to addr 3 during busy is dropped (wr_cnt unchanged); clear_done pulses once; all reads = 0 afterwards.
- Start sweep, assert reset at cycle 10 of the sweep -> next cycle busy=0, no clear_done pulse, all regs 0; also drive wr_en for 2**CNT_W+3 writes -> wr_cnt = 0xFFFF.

Source files
------------

// File: rtl/regfile_bank.sv
// regfile_bank: register bank with two async read ports, one sync write port, clear sweep, write counter and LEDs
// Ports: clk, reset (sync, active-high); rd_addr1/2 -> rd_data1/2 (combinational reads);
//        wr_en/wr_addr/wr_data (write port); clear_req -> busy/clear_done (sweep handshake);
//        wr_cnt (saturating accepted-write count); led (active-low wr_data[3:0] of last accepted write).
// Optional: define REGFILE_BYPASS_EN for same-cycle write-to-read forwarding.
module regfile_bank #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              clear_req,
  output logic              busy,
  output logic              clear_done,
  output logic [CNT_W-1:0]  wr_cnt,
  output logic [3:0]        led
);
  localparam logic [ADDR_W:0]   L_DEPTH = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] L_LAST  = ADDR_W'(DEPTH-1);
  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_DONE} state_t;
  state_t            r_state, w_next;
  logic [ADDR_W-1:0] r_idx;
  logic [DATA_W-1:0] r_regs [DEPTH];
  logic [CNT_W-1:0]  r_cnt;
  logic [3:0]        r_led;
  logic              w_acc, w_store, w_ok1, w_ok2;
  always_ff @(posedge clk) begin
    r_state <= reset ? S_IDLE : w_next;
  end
  always_comb begin
    w_next = r_state == S_IDLE  ? (clear_req ? S_CLEAR : S_IDLE) :
             r_state == S_CLEAR ? (r_idx == L_LAST ? S_DONE : S_CLEAR) : S_IDLE;
  end
  always_comb begin
    busy       = r_state == S_CLEAR;
    clear_done = r_state == S_DONE;
  end
  // A clear request in IDLE takes priority over a simultaneous write.
  always_comb begin
    w_acc   = wr_en && r_state != S_CLEAR && !(r_state == S_IDLE && clear_req);
    w_store = w_acc && wr_addr != '0 && {1'b0, wr_addr} < L_DEPTH;
    w_ok1   = rd_addr1 != '0 && {1'b0, rd_addr1} < L_DEPTH && !busy;
    w_ok2   = rd_addr2 != '0 && {1'b0, rd_addr2} < L_DEPTH && !busy;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
      r_idx <= '0;
      r_cnt <= '0;
      r_led <= '1;
    end else begin
      r_idx <= r_state == S_CLEAR ? r_idx + 1'b1 : '0;
      if (r_state == S_CLEAR) r_regs[r_idx] <= '0;
      if (w_store) r_regs[wr_addr] <= wr_data;
      if (w_acc) begin
        r_cnt <= r_cnt == '1 ? r_cnt : r_cnt + 1'b1;
        r_led <= ~wr_data[3:0];
      end
    end
  end
  always_comb begin
`ifdef REGFILE_BYPASS_EN
    rd_data1 = !w_ok1 ? '0 : (w_store && wr_addr == rd_addr1) ? wr_data : r_regs[rd_addr1];
    rd_data2 = !w_ok2 ? '0 : (w_store && wr_addr == rd_addr2) ? wr_data : r_regs[rd_addr2];
`else
    rd_data1 = w_ok1 ? r_regs[rd_addr1] : '0;
    rd_data2 = w_ok2 ? r_regs[rd_addr2] : '0;
`endif
  end
  assign wr_cnt = r_cnt;
  assign led    = r_led;
endmodule

// File: tb/tb_regfile_bank.sv
// tb_regfile_bank: directed stimulus with a per-cycle behavioural model check and literal spot checks
module tb_regfile_bank;
  localparam int D = 32;
  logic        clk = 0, reset = 1, wr_en = 0, clear_req = 0;
  logic [4:0]  rd_addr1 = 0, rd_addr2 = 0, wr_addr = 0;
  logic [31:0] wr_data = 0, rd_data1, rd_data2;
  logic        busy, clear_done;
  logic [15:0] wr_cnt;
  logic [3:0]  led;
  int          total = 0, bad = 0, nb, nd;
  bit          started = 0;
  logic [31:0] m_regs [D];
  int          m_left = 0, m_cnt = 0;
  bit          m_done = 0, m_done_n, acc;
  logic [3:0]  m_led = 4'hF;
  regfile_bank #(.DATA_W(32), .ADDR_W(5), .DEPTH(D), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(rd_data1), .rd_data2(rd_data2), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .clear_req(clear_req), .busy(busy), .clear_done(clear_done),
    .wr_cnt(wr_cnt), .led(led)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  function automatic bit m_accept();
    return wr_en && m_left == 0 && !(!m_done && clear_req);
  endfunction
  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 0 || int'(a) >= D || m_left > 0) return 0;
`ifdef REGFILE_BYPASS_EN
    if (m_accept() && wr_addr == a) return wr_data;
`endif
    return m_regs[a];
  endfunction
  always @(posedge clk) begin
    acc = m_accept();
    if (reset) begin
      foreach (m_regs[i]) m_regs[i] = 0;
      m_left = 0; m_done = 0; m_cnt = 0; m_led = 4'hF;
    end else begin
      m_done_n = 0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          foreach (m_regs[i]) m_regs[i] = 0;
          m_done_n = 1;
        end
      end else if (!m_done && clear_req) m_left = D;
      if (acc) begin
        if (wr_addr != 0) m_regs[wr_addr] = wr_data;
        if (m_cnt < 65535) m_cnt++;
        m_led = ~wr_data[3:0];
      end
      m_done = m_done_n;
    end
  end
  always @(negedge clk) if (started) begin
    chk("model rd_data1", rd_data1, m_read(rd_addr1));
    chk("model rd_data2", rd_data2, m_read(rd_addr2));
    chk("model busy", 32'(busy), 32'(m_left > 0));
    chk("model clear_done", 32'(clear_done), 32'(m_done));
    chk("model wr_cnt", 32'(wr_cnt), 32'(m_cnt));
    chk("model led", 32'(led), 32'(m_led));
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    wr_en = 1; wr_addr = a; wr_data = d;
    step();
    wr_en = 0;
  endtask
  task automatic sweep_watch();
    nb = 0; nd = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      nb += int'(busy);
      nd += int'(clear_done);
      #2;
      wr_en = 0; clear_req = 0;
      if (c == 5) begin wr_en = 1; wr_addr = 3; wr_data = 32'h33333333; end
      if (clear_done) begin wr_en = 1; wr_addr = 12; wr_data = 32'hC0FFEE00; clear_req = 1; end
    end
    wr_en = 0; clear_req = 0;
  endtask
  initial begin
    rd_addr1 = 5; rd_addr2 = 9;
    step(); step();
    reset = 0; started = 1;
    @(negedge clk);
    chk("reset rd_data1", rd_data1, 0);
    chk("reset rd_data2", rd_data2, 0);
    chk("reset led", 32'(led), 32'hF);
    chk("reset wr_cnt", 32'(wr_cnt), 0);
    chk("reset busy", 32'(busy), 0);
    step();
    wr(5, 32'hDEADBEEF);
    rd_addr1 = 5; rd_addr2 = 5;
    @(negedge clk);
    chk("addr5 rd1", rd_data1, 32'hDEADBEEF);
    chk("addr5 rd2", rd_data2, 32'hDEADBEEF);
    chk("addr5 led", 32'(led), 32'h0);
    chk("addr5 cnt", 32'(wr_cnt), 1);
    step();
    wr(0, 32'h12345678);
    rd_addr1 = 0;
    @(negedge clk);
    chk("addr0 rd1", rd_data1, 0);
    chk("addr0 cnt", 32'(wr_cnt), 2);
    chk("addr0 led", 32'(led), 32'h7);
    step();
    wr(7, 32'h1);
    rd_addr1 = 7; rd_addr2 = 7;
    wr_en = 1; wr_addr = 7; wr_data = 32'hA5A5A5A5;
    @(negedge clk);
`ifdef REGFILE_BYPASS_EN
    chk("same-cycle rd1", rd_data1, 32'hA5A5A5A5);
`else
    chk("same-cycle rd1", rd_data1, 32'h1);
`endif
    step();
    wr_en = 0;
    @(negedge clk);
    chk("next-cycle rd1", rd_data1, 32'hA5A5A5A5);
    chk("next-cycle cnt", 32'(wr_cnt), 4);
    step();
    for (int i = 1; i < D; i++) wr(5'(i), 32'h10000000 + i);
    rd_addr1 = 20;
    @(negedge clk);
    chk("fill rd20", rd_data1, 32'h10000014);
    step();
    clear_req = 1; wr_en = 1; wr_addr = 9; wr_data = 32'hFFFFFFFF;
    step();
    clear_req = 0; wr_en = 0;
    sweep_watch();
    chk("busy cycles", nb, 32);
    chk("done pulses", nd, 1);
    chk("cnt after sweep", 32'(wr_cnt), 36);
    for (int a = 0; a < D; a++) begin
      step();
      rd_addr1 = 5'(a); rd_addr2 = 5'(D - 1 - a);
      @(negedge clk);
      chk("post-clear rd1", rd_data1, a == 12 ? 32'hC0FFEE00 : 0);
    end
    step();
    wr(4, 32'h44); wr(6, 32'h66);
    clear_req = 1;
    step();
    clear_req = 0;
    repeat (10) step();
    reset = 1;
    step();
    reset = 0;
    rd_addr1 = 4; rd_addr2 = 6;
    @(negedge clk);
    chk("abort busy", 32'(busy), 0);
    chk("abort cnt", 32'(wr_cnt), 0);
    chk("abort rd4", rd_data1, 0);
    chk("abort rd6", rd_data2, 0);
    nd = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      nd += int'(clear_done);
    end
    chk("abort no done", nd, 0);
    step();
    wr_en = 1;
    for (int i = 0; i < 65539; i++) begin
      wr_addr = 5'(i % 32); wr_data = i;
      step();
    end
    wr_en = 0;
    rd_addr1 = 2;
    @(negedge clk);
    chk("sat cnt", 32'(wr_cnt), 32'hFFFF);
    chk("sat led", 32'(led), 32'hD);
    chk("sat rd2", rd_data1, 32'h10002);
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
